// File: rtl/fp_align_add_pipe.sv
// Three-stage floating-point adder: S1 compare/swap/align, S2 add/subtract, S3 normalise/round.
// Subnormals are flushed to zero, rounding is nearest-even, and the valid/ready pipeline collapses bubbles.
module fp_align_add_pipe #(
  parameter int EXP_W  = 8,
  parameter int MANT_W = 23
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [EXP_W+MANT_W:0]   op_a,
  input  logic [EXP_W+MANT_W:0]   op_b,
  input  logic                    sub,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [EXP_W+MANT_W:0]   result,
  output logic                    inexact,
  output logic                    overflow
);

  localparam int W  = 1 + EXP_W + MANT_W;
  localparam int F  = MANT_W + 4;          // {hidden, mant, guard, round, sticky}
  localparam int X  = 2 * MANT_W + 7;      // alignment field plus every bit that can be shifted out
  localparam int SW = MANT_W + 3;
  localparam int ES = EXP_W + 8;
  localparam logic [EXP_W-1:0]         EXP_ONES = '1;
  localparam logic signed [ES-1:0]     EXP_MAX  = ES'((1 << EXP_W) - 1);

  // Stage registers
  logic                 s1_valid_q, s1_valid_d;
  logic                 s1_sign_q, s1_sign_d;
  logic                 s1_eff_sub_q, s1_eff_sub_d;
  logic [EXP_W-1:0]     s1_exp_q, s1_exp_d;
  logic [F-1:0]         s1_big_q, s1_big_d;
  logic [F-1:0]         s1_lit_q, s1_lit_d;
  logic                 s1_inf_q, s1_inf_d;
  logic                 s1_inf_sign_q, s1_inf_sign_d;
  logic                 s1_inf_ovf_q, s1_inf_ovf_d;

  logic                 s2_valid_q, s2_valid_d;
  logic                 s2_sign_q, s2_sign_d;
  logic [EXP_W-1:0]     s2_exp_q, s2_exp_d;
  logic [F:0]           s2_sum_q, s2_sum_d;
  logic                 s2_inf_q, s2_inf_d;
  logic                 s2_inf_sign_q, s2_inf_sign_d;
  logic                 s2_inf_ovf_q, s2_inf_ovf_d;

  logic                 s3_valid_q, s3_valid_d;
  logic [W-1:0]         s3_result_q, s3_result_d;
  logic                 s3_inexact_q, s3_inexact_d;
  logic                 s3_overflow_q, s3_overflow_d;

  // Handshake: each stage advances when the one after it can take its contents
  logic en1, en2, en3, accept;

  always_comb begin
    en3    = out_ready | ~s3_valid_q;
    en2    = en3 | ~s2_valid_q;
    en1    = en2 | ~s1_valid_q;
    accept = in_valid & en3;
  end

  assign in_ready  = en3;
  assign out_valid = s3_valid_q;
  assign result    = s3_result_q;
  assign inexact   = s3_inexact_q;
  assign overflow  = s3_overflow_q;

  // S1: decode, compare, swap, align
  logic [EXP_W-1:0]  ea, eb, e_big, e_lit, diff;
  logic [MANT_W-1:0] ma, mb;
  logic              sa, sb_eff, a_zero, b_zero, a_inf, b_inf, b_is_big;
  logic [MANT_W:0]   sig_a, sig_b, sig_big, sig_lit;
  logic [15:0]       shift;
  logic [X-1:0]      ext, ext_sh;
  logic [F-1:0]      lit_al;
  logic              inf_sign, inf_ovf;

  always_comb begin
    sa     = op_a[W-1];
    sb_eff = op_b[W-1] ^ sub;
    ea     = op_a[W-2:MANT_W];
    eb     = op_b[W-2:MANT_W];
    ma     = op_a[MANT_W-1:0];
    mb     = op_b[MANT_W-1:0];
    a_zero = (ea == '0);
    b_zero = (eb == '0);
    a_inf  = (ea == EXP_ONES);
    b_inf  = (eb == EXP_ONES);
    if (a_zero || a_inf) ma = '0;
    if (b_zero || b_inf) mb = '0;
    sig_a    = {~a_zero, ma};
    sig_b    = {~b_zero, mb};
    b_is_big = ({eb, mb} > {ea, ma});
    e_big    = b_is_big ? eb : ea;
    e_lit    = b_is_big ? ea : eb;
    sig_big  = b_is_big ? sig_b : sig_a;
    sig_lit  = b_is_big ? sig_a : sig_b;
    diff     = e_big - e_lit;
    if (16'(diff) > 16'(SW)) shift = 16'(SW);
    else                     shift = 16'(diff);
    ext    = {sig_lit, {(MANT_W + 6){1'b0}}};
    ext_sh = ext >> shift;
    lit_al = {ext_sh[X-1:X-F+1], ext_sh[X-F] | (|ext_sh[X-F-1:0])};
    // Opposing infinities have no defined sign; they resolve to +inf and flag overflow
    inf_ovf  = 1'b0;
    if (a_inf && b_inf && (sa != sb_eff)) begin
      inf_sign = 1'b0;
      inf_ovf  = 1'b1;
    end else if (a_inf) begin
      inf_sign = sa;
    end else begin
      inf_sign = sb_eff;
    end
  end

  // S3: normalise, round, classify
  logic [6:0]              lz;
  logic [F-1:0]            norm;
  logic signed [ES-1:0]    exp_n, exp_f;
  logic                    g_bit, r_bit, st_bit, round_up;
  logic [MANT_W+1:0]       mant_r;
  logic [MANT_W-1:0]       mant_f;

  always_comb begin
    lz = '0;
    for (int i = 0; i < F; i++) begin
      if (s2_sum_q[i]) lz = 7'(F - 1 - i);
    end
    if (s2_sum_q[F]) begin
      norm  = {s2_sum_q[F:2], s2_sum_q[1] | s2_sum_q[0]};
      exp_n = $signed(ES'(s2_exp_q)) + $signed(ES'(1));
    end else begin
      norm  = s2_sum_q[F-1:0] << lz;
      exp_n = $signed(ES'(s2_exp_q)) - $signed(ES'(lz));
    end
    g_bit    = norm[2];
    r_bit    = norm[1];
    st_bit   = norm[0];
    round_up = g_bit & (r_bit | st_bit | norm[3]);
    mant_r   = {1'b0, norm[F-1:3]} + (MANT_W + 2)'(round_up);
    exp_f    = exp_n + $signed(ES'(mant_r[MANT_W+1]));
    mant_f   = mant_r[MANT_W+1] ? mant_r[MANT_W:1] : mant_r[MANT_W-1:0];
  end

  // Next-state for all stages
  always_comb begin
    s1_valid_d    = s1_valid_q;
    s1_sign_d     = s1_sign_q;
    s1_eff_sub_d  = s1_eff_sub_q;
    s1_exp_d      = s1_exp_q;
    s1_big_d      = s1_big_q;
    s1_lit_d      = s1_lit_q;
    s1_inf_d      = s1_inf_q;
    s1_inf_sign_d = s1_inf_sign_q;
    s1_inf_ovf_d  = s1_inf_ovf_q;
    s2_valid_d    = s2_valid_q;
    s2_sign_d     = s2_sign_q;
    s2_exp_d      = s2_exp_q;
    s2_sum_d      = s2_sum_q;
    s2_inf_d      = s2_inf_q;
    s2_inf_sign_d = s2_inf_sign_q;
    s2_inf_ovf_d  = s2_inf_ovf_q;
    s3_valid_d    = s3_valid_q;
    s3_result_d   = s3_result_q;
    s3_inexact_d  = s3_inexact_q;
    s3_overflow_d = s3_overflow_q;

    if (en1) s1_valid_d = accept;
    if (accept) begin
      s1_sign_d     = b_is_big ? sb_eff : sa;
      s1_eff_sub_d  = sa ^ sb_eff;
      s1_exp_d      = e_big;
      s1_big_d      = {sig_big, 3'b000};
      s1_lit_d      = lit_al;
      s1_inf_d      = a_inf | b_inf;
      s1_inf_sign_d = inf_sign;
      s1_inf_ovf_d  = inf_ovf;
    end

    if (en2) s2_valid_d = s1_valid_q;
    if (en2 && s1_valid_q) begin
      s2_sign_d     = s1_sign_q;
      s2_exp_d      = s1_exp_q;
      s2_sum_d      = s1_eff_sub_q ? ({1'b0, s1_big_q} - {1'b0, s1_lit_q})
                                   : ({1'b0, s1_big_q} + {1'b0, s1_lit_q});
      s2_inf_d      = s1_inf_q;
      s2_inf_sign_d = s1_inf_sign_q;
      s2_inf_ovf_d  = s1_inf_ovf_q;
    end

    if (en3) s3_valid_d = s2_valid_q;
    if (en3 && s2_valid_q) begin
      s3_inexact_d  = g_bit | r_bit | st_bit;
      s3_overflow_d = 1'b0;
      if (s2_inf_q) begin
        s3_result_d   = {s2_inf_sign_q, EXP_ONES, {MANT_W{1'b0}}};
        s3_inexact_d  = 1'b0;
        s3_overflow_d = s2_inf_ovf_q;
      end else if (s2_sum_q == '0) begin
        s3_result_d   = '0;
        s3_inexact_d  = 1'b0;
      end else if (exp_f >= EXP_MAX) begin
        s3_result_d   = {s2_sign_q, EXP_ONES, {MANT_W{1'b0}}};
        s3_overflow_d = 1'b1;
      end else if (exp_f <= 0) begin
        s3_result_d   = {s2_sign_q, {(W - 1){1'b0}}};
      end else begin
        s3_result_d   = {s2_sign_q, exp_f[EXP_W-1:0], mant_f};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q    <= 1'b0;
      s1_sign_q     <= 1'b0;
      s1_eff_sub_q  <= 1'b0;
      s1_exp_q      <= '0;
      s1_big_q      <= '0;
      s1_lit_q      <= '0;
      s1_inf_q      <= 1'b0;
      s1_inf_sign_q <= 1'b0;
      s1_inf_ovf_q  <= 1'b0;
      s2_valid_q    <= 1'b0;
      s2_sign_q     <= 1'b0;
      s2_exp_q      <= '0;
      s2_sum_q      <= '0;
      s2_inf_q      <= 1'b0;
      s2_inf_sign_q <= 1'b0;
      s2_inf_ovf_q  <= 1'b0;
      s3_valid_q    <= 1'b0;
      s3_result_q   <= '0;
      s3_inexact_q  <= 1'b0;
      s3_overflow_q <= 1'b0;
    end else begin
      s1_valid_q    <= s1_valid_d;
      s1_sign_q     <= s1_sign_d;
      s1_eff_sub_q  <= s1_eff_sub_d;
      s1_exp_q      <= s1_exp_d;
      s1_big_q      <= s1_big_d;
      s1_lit_q      <= s1_lit_d;
      s1_inf_q      <= s1_inf_d;
      s1_inf_sign_q <= s1_inf_sign_d;
      s1_inf_ovf_q  <= s1_inf_ovf_d;
      s2_valid_q    <= s2_valid_d;
      s2_sign_q     <= s2_sign_d;
      s2_exp_q      <= s2_exp_d;
      s2_sum_q      <= s2_sum_d;
      s2_inf_q      <= s2_inf_d;
      s2_inf_sign_q <= s2_inf_sign_d;
      s2_inf_ovf_q  <= s2_inf_ovf_d;
      s3_valid_q    <= s3_valid_d;
      s3_result_q   <= s3_result_d;
      s3_inexact_q  <= s3_inexact_d;
      s3_overflow_q <= s3_overflow_d;
    end
  end

endmodule

// File: doc/fp_align_add_pipe.md
FP_ALIGN_ADD_PIPE -- requirements
Module: fp_align_add_pipe

Interface
REQ-001 The block SHALL have parameter EXP_W, default 8, exponent field width.
REQ-002 The block SHALL have parameter MANT_W, default 23, stored mantissa width (hidden bit excluded).
REQ-003 Derived width W = 1+EXP_W+MANT_W; the block SHALL accept EXP_W 4..11 and MANT_W 7..52.
REQ-004 The block SHALL have one clock; reset is synchronous and active-low.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst_n  input  1  synchronous active-low reset.
REQ-007 in_valid  input  1  operand pair present.
REQ-008 in_ready  output  1  block accepts the operand pair this cycle.
REQ-009 op_a  input  W  operand A {sign, exp, mant}.
REQ-010 op_b  input  W  operand B {sign, exp, mant}.
REQ-011 sub  input  1  0: A+B, 1: A-B (B sign inverted).
REQ-012 out_valid  output  1  result present.
REQ-013 out_ready  input  1  consumer accepts the result.
REQ-014 result  output  W  sum {sign, exp, mant}.
REQ-015 inexact  output  1  rounding discarded nonzero bits.
REQ-016 overflow  output  1  result saturated to infinity.

Function
REQ-017 Transfer occurs on a cycle with valid and ready both high, on input and output independently.
REQ-018 Three stages: S1 compare/swap/align, S2 add/subtract, S3 normalise/round; latency SHALL be exactly 3 cycles from input transfer to out_valid when out_ready stays high.
REQ-019 Throughput SHALL be one operation per cycle without backpressure.
REQ-020 Stall: when out_valid=1 and out_ready=0, all stages SHALL hold; in_ready = out_ready or not out_valid.
REQ-021 Bubbles SHALL collapse: an empty stage SHALL accept the preceding stage's contents even while a later stage is stalled.
REQ-022 S1: the operand with larger {exp,mant} SHALL become "big"; equal magnitudes keep A as big.
REQ-023 S1: shift = exp_big - exp_little as an unsigned EXP_W-bit difference, saturated to MANT_W+3.
REQ-024 S1: the little significand (hidden bit prepended) SHALL shift right into a MANT_W+4-bit field with guard, round and sticky bits; sticky = OR of all shifted-out bits.
REQ-025 Exp field 0 SHALL read as zero (subnormals flushed, mantissa ignored); exp all-ones SHALL read as infinity (mantissa ignored).
REQ-026 S2: equal effective signs add, with a carry bit; different signs subtract little from big; result sign = sign of big.
REQ-027 S3: a carry SHALL shift right by 1 and increment the exponent, sticky absorbing the lost bit; otherwise leading zeros SHALL shift left, decrementing the exponent.
REQ-028 S3: round-to-nearest-even on guard/round/sticky; a rounding carry SHALL renormalise.
REQ-029 Zero sum SHALL give +0; exponent underflow (<=0) SHALL flush to signed zero.
REQ-030 Exponent reaching all-ones SHALL give signed infinity (mant 0) and overflow=1.
REQ-031 Any infinite input SHALL give infinity of that sign; inf minus inf SHALL give +inf with overflow=1.
REQ-032 inexact SHALL be 1 when any of guard/round/sticky was nonzero before rounding, else 0.
REQ-033 result, inexact and overflow SHALL be stable while out_valid=1 and out_ready=0.

Reset
REQ-034 With rst_n=0 at a clock edge, all stage valids, out_valid, result, inexact and overflow SHALL clear to 0; in_ready SHALL be 1 from the first cycle after reset.
REQ-035 Reset mid-operation SHALL discard all in-flight operations; none SHALL appear after release.

Verification
REQ-036 0x3F800000 + 0x3F800000, sub=0 -> result 0x40000000 on cycle 3, inexact=0.
REQ-037 0x3F800000 with sub=1 on 0x3F800000 -> result 0x00000000, inexact=0, overflow=0.
REQ-038 0x3F800000 + 0x30800000 (2^-30) -> result 0x3F800000, inexact=1 (saturated shift, sticky).
REQ-039 0x7F7FFFFF + 0x7F7FFFFF -> result 0x7F800000, overflow=1.
REQ-040 Five back-to-back inputs, out_ready low cycles 2-6 -> in_ready low when full, five ordered results, none lost or duplicated, outputs constant while stalled.
REQ-041 rst_n low for one cycle with three operations in flight -> out_valid stays 0 afterwards until a new input is accepted.
